// File: rtl/bus_sched_pkg.sv
// rtl/bus_sched_pkg.sv - shared types and default widths for the burst bus scheduler
package bus_sched_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int SW_DEF = 4;
    localparam int GW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [SW_DEF-1:0] size;
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, pointer moves only on a grant
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_idx,
    output logic       o_any
);

    logic r_last;
    logic w_pick;

    // r_last resets to 1 so port 0 is preferred on the first contested grant
    always_comb begin
        w_pick = 1'b0;
        if (i_req == 2'b11) begin
            w_pick = ~r_last;
        end else if (i_req[1]) begin
            w_pick = 1'b1;
        end
    end

    assign o_any = i_en && (i_req != 2'b00);
    assign o_idx = w_pick;
    assign o_gnt = o_any ? (w_pick ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (o_any) begin
            r_last <= w_pick;
        end
    end

endmodule

// File: rtl/bus_burst_scheduler.sv
// rtl/bus_burst_scheduler.sv - shares one burst bus between two requesters with round-robin
module bus_burst_scheduler
    import bus_sched_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int SW = SW_DEF,
    parameter int GW = GW_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [GW-1:0]       gap_cycles,
    input  logic [1:0]          rq_valid,
    input  logic [1:0][AW-1:0]  rq_addr,
    input  logic [1:0][SW-1:0]  rq_size,
    output logic [1:0]          rq_ready,
    input  logic [1:0][DW-1:0]  rq_wdata,
    output logic [1:0]          rq_wready,
    input  logic                bus_stall,
    output logic                bus_start,
    output logic [AW-1:0]       bus_addr,
    output logic [SW-1:0]       bus_size,
    output logic [DW-1:0]       bus_data,
    output logic                bus_dvalid,
    output logic                bus_owner,
    output logic                busy
);

    state_e          r_state;
    state_e          w_next;
    req_t            r_req;
    logic            r_owner;
    logic [SW:0]     r_beat;
    logic [GW-1:0]   r_gap;
    logic [DW-1:0]   r_data;

    logic [1:0]      w_gnt;
    logic            w_idx;
    logic            w_any;
    logic            w_fire;
    logic            w_last_beat;
    logic            w_enter_gap;

    rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .i_en  (r_state == IDLE),
        .i_req (rq_valid),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_fire      = (r_state == DATA) && !bus_stall;
    assign w_last_beat = w_fire && ((r_beat + 1'b1) == {1'b0, r_req.size});

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_next = START;
            START: begin
                if (r_req.size != '0) begin
                    w_next = DATA;
                end else begin
                    w_next = (gap_cycles == '0) ? IDLE : GAP;
                end
            end
            DATA:    if (w_last_beat) w_next = (gap_cycles == '0) ? IDLE : GAP;
            GAP:     if (r_gap == GW'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_enter_gap = (w_next == GAP) && (r_state != GAP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_owner <= 1'b0;
            r_beat  <= '0;
            r_gap   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_req.addr <= rq_addr[w_idx];
                r_req.size <= rq_size[w_idx];
                r_owner    <= w_idx;
            end
            if (r_state == START) begin
                r_beat <= '0;
            end else if (w_fire) begin
                r_beat <= r_beat + 1'b1;
            end
            // gap length is captured once so a changing gap_cycles cannot stretch a gap
            if (w_enter_gap) begin
                r_gap <= gap_cycles;
            end else if (r_state == GAP) begin
                r_gap <= r_gap - 1'b1;
            end
            if (w_fire) begin
                r_data <= rq_wdata[r_owner];
            end
        end
    end

    assign rq_ready   = w_gnt;
    assign rq_wready  = w_fire ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign bus_start  = (r_state == START);
    assign bus_addr   = r_req.addr;
    assign bus_size   = r_req.size;
    assign bus_dvalid = w_fire;
    assign bus_data   = w_fire ? rq_wdata[r_owner] : r_data;
    assign bus_owner  = r_owner;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_bus_burst_scheduler.sv
// tb/tb_bus_burst_scheduler.sv - randomized bench against a burst-timeline reference model
module tb_bus_burst_scheduler;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int GW = 4;
    localparam int NC = 1024;

    logic                clock = 1'b0;
    logic                reset;
    logic [GW-1:0]       gap_cycles;
    logic [1:0]          rq_valid;
    logic [1:0][AW-1:0]  rq_addr;
    logic [1:0][SW-1:0]  rq_size;
    logic [1:0]          rq_ready;
    logic [1:0][DW-1:0]  rq_wdata;
    logic [1:0]          rq_wready;
    logic                bus_stall;
    logic                bus_start;
    logic [AW-1:0]       bus_addr;
    logic [SW-1:0]       bus_size;
    logic [DW-1:0]       bus_data;
    logic                bus_dvalid;
    logic                bus_owner;
    logic                busy;

    bus_burst_scheduler #(.AW(AW), .DW(DW), .SW(SW), .GW(GW)) dut (
        .clock      (clock),
        .reset      (reset),
        .gap_cycles (gap_cycles),
        .rq_valid   (rq_valid),
        .rq_addr    (rq_addr),
        .rq_size    (rq_size),
        .rq_ready   (rq_ready),
        .rq_wdata   (rq_wdata),
        .rq_wready  (rq_wready),
        .bus_stall  (bus_stall),
        .bus_start  (bus_start),
        .bus_addr   (bus_addr),
        .bus_size   (bus_size),
        .bus_data   (bus_data),
        .bus_dvalid (bus_dvalid),
        .bus_owner  (bus_owner),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // request lists per port, stall pattern, and model-side bookkeeping
    int              n_req [2];
    logic [AW-1:0]   q_addr [2][16];
    logic [SW-1:0]   q_size [2][16];
    bit              stall_pat [NC];
    int              last_port = 1;
    int              m_bc [2];
    int              wcnt [2];

    bit              e_start  [NC];
    bit              e_dvalid [NC];
    bit              e_busy   [NC];
    bit              e_owner  [NC];
    bit [1:0]        e_ready  [NC];
    bit [1:0]        e_wready [NC];
    logic [AW-1:0]   e_addr   [NC];
    logic [SW-1:0]   e_size   [NC];
    logic [DW-1:0]   e_data   [NC];

    task automatic clear_q();
        n_req = '{0, 0};
        for (int i = 0; i < NC; i++) stall_pat[i] = 1'b0;
    endtask

    task automatic add_req(input int p, input logic [AW-1:0] a, input int s);
        q_addr[p][n_req[p]] = a;
        q_size[p][n_req[p]] = SW'(s);
        n_req[p]++;
    endtask

    // Timeline model: grant at t, start at t+1, beats on unstalled cycles from t+2, then g idle cycles.
    task automatic build_model(input int g, output int ncyc);
        int t, lp, p, c, k, fin;
        int idx [2];
        t = 0;
        lp = last_port;
        idx = '{0, 0};
        for (int i = 0; i < NC; i++) begin
            e_start[i] = 0; e_dvalid[i] = 0; e_busy[i] = 0; e_owner[i] = 0;
            e_ready[i] = 0; e_wready[i] = 0; e_addr[i] = 0; e_size[i] = 0; e_data[i] = 0;
        end
        while (idx[0] < n_req[0] || idx[1] < n_req[1]) begin
            if (idx[0] < n_req[0] && idx[1] < n_req[1]) p = 1 - lp;
            else p = (idx[0] < n_req[0]) ? 0 : 1;
            lp = p;
            e_ready[t][p] = 1'b1;
            e_start[t+1] = 1'b1;
            e_addr[t+1]  = q_addr[p][idx[p]];
            e_size[t+1]  = q_size[p][idx[p]];
            c = t + 2;
            k = 0;
            while (k < int'(q_size[p][idx[p]])) begin
                if (!stall_pat[c]) begin
                    e_dvalid[c]    = 1'b1;
                    e_wready[c][p] = 1'b1;
                    e_data[c]      = {8'(8'hA0 + p), 24'(m_bc[p])};
                    m_bc[p]++;
                    k++;
                end
                c++;
            end
            fin = c + g;
            for (int i = t + 1; i < fin; i++) begin
                e_busy[i]  = 1'b1;
                e_owner[i] = (p == 1);
            end
            t = fin;
            idx[p]++;
        end
        last_port = lp;
        ncyc = t + 3;
    endtask

    task automatic run_scen(input string name, input int g);
        int ncyc;
        int qi [2];
        build_model(g, ncyc);
        qi = '{0, 0};
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            gap_cycles = GW'(g);
            bus_stall  = stall_pat[c];
            for (int p = 0; p < 2; p++) begin
                rq_valid[p] = (qi[p] < n_req[p]);
                rq_addr[p]  = q_addr[p][qi[p]];
                rq_size[p]  = q_size[p][qi[p]];
                rq_wdata[p] = {8'(8'hA0 + p), 24'(wcnt[p])};
            end
            #1;
            check_eq($sformatf("%s rq_ready@%0d", name, c), rq_ready, e_ready[c]);
            check_eq($sformatf("%s bus_start@%0d", name, c), bus_start, e_start[c]);
            check_eq($sformatf("%s bus_dvalid@%0d", name, c), bus_dvalid, e_dvalid[c]);
            check_eq($sformatf("%s rq_wready@%0d", name, c), rq_wready, e_wready[c]);
            check_eq($sformatf("%s busy@%0d", name, c), busy, e_busy[c]);
            if (e_start[c]) begin
                check_eq($sformatf("%s bus_addr@%0d", name, c), bus_addr, e_addr[c]);
                check_eq($sformatf("%s bus_size@%0d", name, c), bus_size, e_size[c]);
            end
            if (e_dvalid[c]) check_eq($sformatf("%s bus_data@%0d", name, c), bus_data, e_data[c]);
            if (e_busy[c]) check_eq($sformatf("%s bus_owner@%0d", name, c), bus_owner, e_owner[c]);
            for (int p = 0; p < 2; p++) begin
                if (rq_ready[p] && qi[p] < n_req[p]) qi[p]++;
                if (rq_wready[p]) wcnt[p]++;
            end
        end
        rq_valid = 2'b00;
    endtask

    task automatic check_quiet(input string name);
        check_eq({name, " busy"}, busy, 1'b0);
        check_eq({name, " bus_start"}, bus_start, 1'b0);
        check_eq({name, " bus_dvalid"}, bus_dvalid, 1'b0);
        check_eq({name, " rq_wready"}, rq_wready, 2'b00);
        check_eq({name, " bus_addr"}, bus_addr, '0);
        check_eq({name, " bus_size"}, bus_size, '0);
        check_eq({name, " bus_data"}, bus_data, '0);
        check_eq({name, " bus_owner"}, bus_owner, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        gap_cycles = '0;
        rq_valid   = 2'b00;
        rq_addr    = '0;
        rq_size    = '0;
        rq_wdata   = '0;
        bus_stall  = 1'b0;
        m_bc       = '{0, 0};
        wcnt       = '{0, 0};
        repeat (3) @(negedge clock);
        #1;
        check_quiet("reset");
        check_eq("reset rq_ready", rq_ready, 2'b00);
        @(negedge clock);
        reset = 1'b0;

        clear_q(); add_req(0, 32'h100, 3);
        run_scen("single", 2);

        clear_q();
        add_req(0, 32'h1000, 2); add_req(0, 32'h1010, 1);
        add_req(1, 32'h2000, 2); add_req(1, 32'h2010, 3);
        run_scen("both", 1);

        clear_q(); add_req(0, 32'h300, 5);
        for (int i = 4; i < 8; i++) stall_pat[i] = 1'b1;
        run_scen("stall", 1);

        clear_q(); add_req(1, 32'h400, 0); add_req(0, 32'h500, 0);
        run_scen("size0", 3);

        clear_q(); add_req(0, 32'h600, 2); add_req(1, 32'h700, 2);
        run_scen("gap0", 0);

        clear_q(); add_req(1, 32'h800, 15); add_req(0, 32'h900, 15);
        run_scen("max", 15);

        for (int r = 0; r < 6; r++) begin
            clear_q();
            for (int p = 0; p < 2; p++) begin
                int n;
                n = int'($urandom_range(0, 4));
                for (int j = 0; j < n; j++) add_req(p, $urandom, int'($urandom_range(0, 15)));
            end
            for (int i = 0; i < NC; i++) stall_pat[i] = ($urandom_range(0, 9) < 3);
            run_scen($sformatf("rand%0d", r), int'($urandom_range(0, 15)));
        end

        // reset during the second data beat of a port 1 burst
        @(negedge clock);
        gap_cycles  = GW'(1);
        bus_stall   = 1'b0;
        rq_valid    = 2'b10;
        rq_addr[1]  = 32'hA00;
        rq_size[1]  = SW'(6);
        rq_wdata[1] = 32'h1234_5678;
        #1;
        check_eq("rst_mid grant", rq_ready, 2'b10);
        @(negedge clock);
        rq_valid = 2'b00;
        #1;
        check_eq("rst_mid start", bus_start, 1'b1);
        @(negedge clock);
        #1;
        check_eq("rst_mid beat1", bus_dvalid, 1'b1);
        @(negedge clock);
        #1;
        check_eq("rst_mid beat2", bus_dvalid, 1'b1);
        reset = 1'b1;
        #1;
        check_quiet("rst_mid");
        @(negedge clock);
        reset     = 1'b0;
        last_port = 1;
        m_bc      = '{0, 0};
        wcnt      = '{0, 0};
        clear_q(); add_req(1, 32'hB00, 2); add_req(0, 32'hC00, 1);
        run_scen("after_rst", 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
